// File: rtl/axil_mitm_tap.sv
// AXI4-Lite man-in-the-middle tap. Forwards write/read transactions downstream,
// answering accesses inside a watch window locally with SLVERR when block_en is high.
// Independent write and read FSMs, one outstanding transaction each, with
// saturating statistics counters.
// Optional: define AXIL_MITM_TAP_TIMEOUT_EN for the downstream response timeout.
module axil_mitm_tap #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] WATCH_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] WATCH_MASK = '0,
  parameter int unsigned           TIMEOUT    = 256,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  input  logic                  block_en,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StFwd, StWait, StResp} state_e;

  localparam logic [1:0] RespSlvErr = 2'b10;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return (WATCH_MASK != '0) && ((a & WATCH_MASK) == (WATCH_BASE & WATCH_MASK));
  endfunction

  state_e                wr_st_q, rd_st_q;
  logic                  aw_held_q, w_held_q, wr_local_q, rd_local_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [2:0]            awprot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, rd_cnt_q, err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH:0]    err_sum;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
  logic [31:0]           wr_timer_q, rd_timer_q;
  logic                  wr_stale_q, rd_stale_q;
`endif

  // Slave-side readiness is decoded purely from registered state.
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
  assign s_axil_awready = (wr_st_q == StIdle) && !aw_held_q && !wr_stale_q;
  assign s_axil_wready  = (wr_st_q == StIdle) && !w_held_q && !wr_stale_q;
  assign s_axil_arready = (rd_st_q == StIdle) && !rd_stale_q;
`else
  assign s_axil_awready = (wr_st_q == StIdle) && !aw_held_q;
  assign s_axil_wready  = (wr_st_q == StIdle) && !w_held_q;
  assign s_axil_arready = (rd_st_q == StIdle);
`endif

  logic                  aw_fire, w_fire, aw_have, w_have, ar_fire;
  logic [ADDR_WIDTH-1:0] awaddr_eff;
  logic [2:0]            awprot_eff;
  logic [DATA_WIDTH-1:0] wdata_eff;
  logic [STRB_WIDTH-1:0] wstrb_eff;
  logic                  wr_done, rd_done, wr_err, rd_err;

  // A beat captured this cycle counts as held so the decision costs no extra cycle.
  assign aw_fire    = s_axil_awvalid && s_axil_awready;
  assign w_fire     = s_axil_wvalid && s_axil_wready;
  assign ar_fire    = s_axil_arvalid && s_axil_arready;
  assign aw_have    = aw_held_q || aw_fire;
  assign w_have     = w_held_q || w_fire;
  assign awaddr_eff = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign awprot_eff = aw_held_q ? awprot_q : s_axil_awprot;
  assign wdata_eff  = w_held_q ? wdata_q : s_axil_wdata;
  assign wstrb_eff  = w_held_q ? wstrb_q : s_axil_wstrb;
  assign wr_done    = (wr_st_q == StResp) && s_axil_bvalid && s_axil_bready;
  assign rd_done    = (rd_st_q == StResp) && s_axil_rvalid && s_axil_rready;
  assign wr_err     = wr_done && wr_local_q;
  assign rd_err     = rd_done && rd_local_q;

  // Write path FSM: collect AW/W, decide block vs forward, relay or synthesize B.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q <= StIdle;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      wr_local_q <= 1'b0;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      m_axil_awaddr <= '0;
      m_axil_awprot <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata <= '0;
      m_axil_wstrb <= '0;
      m_axil_wvalid <= 1'b0;
      m_axil_bready <= 1'b0;
      s_axil_bresp <= '0;
      s_axil_bvalid <= 1'b0;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
      wr_timer_q <= '0;
      wr_stale_q <= 1'b0;
`endif
    end else begin
      unique case (wr_st_q)
        StIdle: begin
          if (aw_fire) begin
            aw_held_q <= 1'b1;
            awaddr_q <= s_axil_awaddr;
            awprot_q <= s_axil_awprot;
          end
          if (w_fire) begin
            w_held_q <= 1'b1;
            wdata_q <= s_axil_wdata;
            wstrb_q <= s_axil_wstrb;
          end
          if (aw_have && w_have) begin
            aw_held_q <= 1'b0;
            w_held_q <= 1'b0;
            if (block_en && in_window(awaddr_eff)) begin
              s_axil_bresp <= RespSlvErr;
              s_axil_bvalid <= 1'b1;
              wr_local_q <= 1'b1;
              wr_st_q <= StResp;
            end else begin
              m_axil_awaddr <= awaddr_eff;
              m_axil_awprot <= awprot_eff;
              m_axil_wdata <= wdata_eff;
              m_axil_wstrb <= wstrb_eff;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid <= 1'b1;
              wr_local_q <= 1'b0;
              wr_st_q <= StFwd;
            end
          end
        end
        StFwd: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            wr_st_q <= StWait;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
            wr_timer_q <= '0;
`endif
          end
        end
        StWait: begin
          if (m_axil_bvalid) begin
            s_axil_bresp <= m_axil_bresp;
            s_axil_bvalid <= 1'b1;
            m_axil_bready <= 1'b0;
            wr_st_q <= StResp;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
          end else if (wr_timer_q == 32'(TIMEOUT - 1)) begin
            // Keep bready high so the late response is swallowed while stale.
            s_axil_bresp <= RespSlvErr;
            s_axil_bvalid <= 1'b1;
            wr_local_q <= 1'b1;
            wr_stale_q <= 1'b1;
            wr_st_q <= StResp;
          end else begin
            wr_timer_q <= wr_timer_q + 32'd1;
`endif
          end
        end
        StResp: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            wr_st_q <= StIdle;
          end
        end
      endcase
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
      if (wr_stale_q && m_axil_bvalid) begin
        wr_stale_q <= 1'b0;
        m_axil_bready <= 1'b0;
      end
`endif
    end
  end

  // Read path FSM: same shape as the write path with a single AR beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st_q <= StIdle;
      rd_local_q <= 1'b0;
      m_axil_araddr <= '0;
      m_axil_arprot <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready <= 1'b0;
      s_axil_rdata <= '0;
      s_axil_rresp <= '0;
      s_axil_rvalid <= 1'b0;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
      rd_timer_q <= '0;
      rd_stale_q <= 1'b0;
`endif
    end else begin
      unique case (rd_st_q)
        StIdle: begin
          if (ar_fire) begin
            if (block_en && in_window(s_axil_araddr)) begin
              s_axil_rdata <= '0;
              s_axil_rresp <= RespSlvErr;
              s_axil_rvalid <= 1'b1;
              rd_local_q <= 1'b1;
              rd_st_q <= StResp;
            end else begin
              m_axil_araddr <= s_axil_araddr;
              m_axil_arprot <= s_axil_arprot;
              m_axil_arvalid <= 1'b1;
              rd_local_q <= 1'b0;
              rd_st_q <= StFwd;
            end
          end
        end
        StFwd: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready <= 1'b1;
            rd_st_q <= StWait;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
            rd_timer_q <= '0;
`endif
          end
        end
        StWait: begin
          if (m_axil_rvalid) begin
            s_axil_rdata <= m_axil_rdata;
            s_axil_rresp <= m_axil_rresp;
            s_axil_rvalid <= 1'b1;
            m_axil_rready <= 1'b0;
            rd_st_q <= StResp;
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
          end else if (rd_timer_q == 32'(TIMEOUT - 1)) begin
            s_axil_rdata <= '0;
            s_axil_rresp <= RespSlvErr;
            s_axil_rvalid <= 1'b1;
            rd_local_q <= 1'b1;
            rd_stale_q <= 1'b1;
            rd_st_q <= StResp;
          end else begin
            rd_timer_q <= rd_timer_q + 32'd1;
`endif
          end
        end
        StResp: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            rd_st_q <= StIdle;
          end
        end
      endcase
`ifdef AXIL_MITM_TAP_TIMEOUT_EN
      if (rd_stale_q && m_axil_rvalid) begin
        rd_stale_q <= 1'b0;
        m_axil_rready <= 1'b0;
      end
`endif
    end
  end

  // Write and read local errors can land together, so sum both before saturating.
  always_comb begin
    err_sum = {1'b0, err_cnt_q} + {{CNT_WIDTH{1'b0}}, wr_err} + {{CNT_WIDTH{1'b0}}, rd_err};
    err_cnt_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
  end

  // Saturating statistics counters, bumped at the slave-side response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (wr_done && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (rd_done && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_axil_mitm_tap.sv
// Scoreboard bench for axil_mitm_tap: stimulus pushes expected beats into queues,
// a negedge monitor pops and compares on every DUT handshake.
module tb_axil_mitm_tap;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  logic        block_en;
  logic [15:0] wr_count, rd_count, err_count;

  axil_mitm_tap #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .WATCH_BASE(32'h0000_1000), .WATCH_MASK(32'h0000_F000),
    .TIMEOUT(TO), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
    .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid),
    .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
    .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid),
    .s_axil_rready(s_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid),
    .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
    .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
    .m_axil_rready(m_rready),
    .block_en(block_en), .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int b_seen = 0;
  int r_seen = 0;
  int aw_hs_cyc = 0;
  int b_cyc = 0;

  logic [34:0] exp_maw[$];  // {prot, addr}
  logic [35:0] exp_mw[$];   // {strb, data}
  logic [34:0] exp_mar[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];    // {data, resp}

  logic        silent, release_b;
  logic [31:0] mem [logic [31:0]];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event or expired wait", name);
  endtask

  // Monitor: handshakes observed at negedge complete on the following rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (m_awvalid && m_awready) begin
        aw_hs_cyc = cyc;
        if (exp_maw.size() == 0) fail_now("m_aw_unexpected");
        else check("m_aw", {29'd0, m_awprot, m_awaddr}, {29'd0, exp_maw.pop_front()});
      end
      if (m_wvalid && m_wready) begin
        if (exp_mw.size() == 0) fail_now("m_w_unexpected");
        else check("m_w", {28'd0, m_wstrb, m_wdata}, {28'd0, exp_mw.pop_front()});
      end
      if (m_arvalid && m_arready) begin
        if (exp_mar.size() == 0) fail_now("m_ar_unexpected");
        else check("m_ar", {29'd0, m_arprot, m_araddr}, {29'd0, exp_mar.pop_front()});
      end
      if (s_bvalid && s_bready) begin
        b_seen++;
        b_cyc = cyc;
        if (exp_b.size() == 0) fail_now("s_b_unexpected");
        else check("s_bresp", {62'd0, s_bresp}, {62'd0, exp_b.pop_front()});
      end
      if (s_rvalid && s_rready) begin
        r_seen++;
        if (exp_r.size() == 0) fail_now("s_r_unexpected");
        else check("s_r", {30'd0, s_rdata, s_rresp}, {30'd0, exp_r.pop_front()});
      end
    end
  end

  // Downstream slave model: memory-backed, can withhold B until release_b.
  initial begin
    logic awhs, whs, bhs, arhs, rhs, clr, aw_got, w_got, pend_b;
    logic [31:0] wa, wd, ha, hd, ra;
    aw_got = 0; w_got = 0; pend_b = 0; wa = 0; wd = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    forever begin
      @(negedge clk);
      clr = rst;
      awhs = m_awvalid && m_awready;
      whs = m_wvalid && m_wready;
      bhs = m_bvalid && m_bready;
      arhs = m_arvalid && m_arready;
      rhs = m_rvalid && m_rready;
      ha = m_awaddr; hd = m_wdata; ra = m_araddr;
      @(posedge clk);
      #1;
      if (clr) begin
        aw_got = 0; w_got = 0; pend_b = 0; m_bvalid = 0; m_rvalid = 0;
      end else begin
        if (bhs) m_bvalid = 0;
        if (rhs) m_rvalid = 0;
        if (awhs) begin aw_got = 1; wa = ha; end
        if (whs) begin w_got = 1; wd = hd; end
        if (aw_got && w_got) begin
          mem[wa] = wd;
          aw_got = 0; w_got = 0;
          if (silent) pend_b = 1;
          else begin m_bvalid = 1; m_bresp = 2'b00; end
        end
        if (release_b && pend_b) begin pend_b = 0; m_bvalid = 1; m_bresp = 2'b00; end
        if (arhs) begin
          m_rvalid = 1;
          m_rresp = 2'b00;
          m_rdata = mem.exists(ra) ? mem[ra] : 32'd0;
        end
      end
    end
  end

  // AW and W beats; with w_lead > 0 the W beat goes first and AW follows w_lead cycles later.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input int w_lead);
    bit aw_done = 0, w_done = 0, aw_acc, w_acc;
    int n = 0, since_w = 0;
    @(posedge clk);
    #1;
    s_wdata = d; s_wstrb = 4'hF; s_wvalid = 1;
    s_awaddr = a; s_awprot = 3'b010; s_awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && n < 100) begin
      @(negedge clk);
      aw_acc = s_awvalid && s_awready;
      w_acc = s_wvalid && s_wready;
      @(posedge clk);
      #1;
      if (aw_acc) begin s_awvalid = 0; aw_done = 1; end
      if (w_acc) begin s_wvalid = 0; w_done = 1; end
      if (w_done && !aw_done && !s_awvalid) begin
        since_w++;
        if (since_w >= w_lead) s_awvalid = 1;
      end
      n++;
    end
    if (!(aw_done && w_done)) begin
      fail_now("write_accept");
      s_awvalid = 0; s_wvalid = 0;
    end
  endtask

  task automatic drive_read(input logic [31:0] a);
    bit acc = 0;
    int n = 0;
    @(posedge clk);
    #1;
    s_araddr = a; s_arprot = 3'b001; s_arvalid = 1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_arready;
      @(posedge clk);
      #1;
      n++;
    end
    s_arvalid = 0;
    if (!acc) fail_now("read_accept");
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_seen < target && n < 200) begin @(negedge clk); n++; end
    if (b_seen < target) fail_now("wait_b");
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r_seen < target && n < 200) begin @(negedge clk); n++; end
    if (r_seen < target) fail_now("wait_r");
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic exp_fwd_write(input logic [31:0] a, input logic [31:0] d);
    exp_maw.push_back({3'b010, a});
    exp_mw.push_back({4'hF, d});
  endtask

  initial begin
    rst = 1; block_en = 0; silent = 0; release_b = 0;
    s_awaddr = 0; s_awprot = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_araddr = 0; s_arprot = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 0);
    #1 rst = 0;
    @(negedge clk);
    check("rst_readys", {s_awready, s_wready, s_arready}, 3'b111);
    check("rst_payload", {s_bresp, s_rresp, s_rdata, m_awaddr, m_wdata}, 0);
    check("rst_counts", {wr_count, rd_count, err_count}, 0);

    // Plain forwarded write then read-back through the tap.
    exp_fwd_write(32'h10, 32'hDEAD_BEEF); exp_b.push_back(2'b00);
    drive_write(32'h10, 32'hDEAD_BEEF, 0);
    wait_b(1);
    check("wr_count_1", wr_count, 1);
    exp_mar.push_back({3'b001, 32'h10}); exp_r.push_back({32'hDEAD_BEEF, 2'b00});
    drive_read(32'h10);
    wait_r(1);
    check("rd_count_1", rd_count, 1);

    // Blocked read and write inside the window: local SLVERR, nothing downstream.
    block_en = 1;
    exp_r.push_back({32'd0, 2'b10});
    drive_read(32'h1004);
    wait_r(2);
    check("err_after_blk_rd", err_count, 1);
    exp_b.push_back(2'b10);
    drive_write(32'h1FF0, 32'h1111_2222, 0);
    wait_b(2);
    check("err_after_blk_wr", {wr_count, err_count}, {16'd2, 16'd2});

    // Window hit without block_en, and a miss with block_en: both forwarded.
    block_en = 0;
    exp_fwd_write(32'h1008, 32'h1234_5678); exp_b.push_back(2'b00);
    drive_write(32'h1008, 32'h1234_5678, 0);
    wait_b(3);
    block_en = 1;
    exp_fwd_write(32'h2000, 32'hA5A5_0F0F); exp_b.push_back(2'b00);
    drive_write(32'h2000, 32'hA5A5_0F0F, 0);
    wait_b(4);

    // W beat three cycles ahead of AW.
    exp_fwd_write(32'h20, 32'hCAFE_F00D); exp_b.push_back(2'b00);
    drive_write(32'h20, 32'hCAFE_F00D, 3);
    wait_b(5);
    check("wr_count_5", {wr_count, err_count}, {16'd5, 16'd2});
    exp_mar.push_back({3'b001, 32'h20}); exp_r.push_back({32'hCAFE_F00D, 2'b00});
    drive_read(32'h20);
    wait_r(3);

    // Simultaneous blocked write and read: err_count steps by two at once.
    exp_b.push_back(2'b10); exp_r.push_back({32'd0, 2'b10});
    fork
      drive_write(32'h1100, 32'h0, 0);
      drive_read(32'h1200);
    join
    wait_b(6);
    wait_r(4);
    check("counts_simul", {wr_count, rd_count, err_count}, {16'd6, 16'd4, 16'd4});

    // Reset while the write path waits on a silent downstream.
    block_en = 0; silent = 1;
    exp_fwd_write(32'h30, 32'h55AA_55AA);
    drive_write(32'h30, 32'h55AA_55AA, 0);
    repeat (3) @(negedge clk);
    check("wait_bready", m_bready, 1);
    #1 rst = 1;
    @(negedge clk);
    check("rst_mid_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready}, 0);
    check("rst_mid_counts", {wr_count, rd_count, err_count}, 0);
    #1 rst = 0; silent = 0;
    exp_fwd_write(32'h34, 32'h0BAD_F00D); exp_b.push_back(2'b00);
    drive_write(32'h34, 32'h0BAD_F00D, 0);
    wait_b(7);
    check("wr_after_rst", {wr_count, err_count}, {16'd1, 16'd0});

`ifdef AXIL_MITM_TAP_TIMEOUT_EN
    // Silent downstream: SLVERR after TO cycles in WAIT, late B swallowed afterwards.
    silent = 1;
    exp_fwd_write(32'h40, 32'h7777_8888); exp_b.push_back(2'b10);
    drive_write(32'h40, 32'h7777_8888, 0);
    wait_b(8);
    // Handshake seen one cycle before the WAIT entry edge, bvalid seen one after exit.
    check("timeout_latency", b_cyc - aw_hs_cyc, TO + 1);
    check("timeout_counts", {wr_count, err_count}, {16'd2, 16'd1});
    check("stale_blocks_aw", s_awready, 0);
    @(posedge clk);
    #1 release_b = 1;
    repeat (4) @(negedge clk);
    check("stale_cleared", {s_awready, m_bready}, 2'b10);
    #1 release_b = 0; silent = 0;
    exp_fwd_write(32'h44, 32'h9999_AAAA); exp_b.push_back(2'b00);
    drive_write(32'h44, 32'h9999_AAAA, 0);
    wait_b(9);
    check("wr_after_timeout", wr_count, 3);
`endif

    repeat (5) @(negedge clk);
    check("queues_drained",
          exp_maw.size() + exp_mw.size() + exp_mar.size() + exp_b.size() + exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axil_mitm_tap.md
AXIL_MITM_TAP -- requirements
Module: axil_mitm_tap

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, data width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, wstrb width.
REQ-004 Parameter WATCH_BASE, default 0, watch-window base address.
REQ-005 Parameter WATCH_MASK, default 0, address bits compared; 0 = window matches nothing.
REQ-006 Parameter TIMEOUT, default 256, response-wait limit in cycles (at least 1).
REQ-007 Parameter CNT_WIDTH, default 16, statistics counter width.
REQ-008 clk  in  1  sole clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 s_axil_aw{addr,prot,valid} in ADDR_WIDTH/3/1; s_axil_awready out 1: slave write address.
REQ-011 s_axil_w{data,strb,valid} in DATA_WIDTH/STRB_WIDTH/1; s_axil_wready out 1: slave write data.
REQ-012 s_axil_b{resp,valid} out 2/1; s_axil_bready in 1: slave write response.
REQ-013 s_axil_ar{addr,prot,valid} in ADDR_WIDTH/3/1; s_axil_arready out 1: slave read address.
REQ-014 s_axil_r{data,resp,valid} out DATA_WIDTH/2/1; s_axil_rready in 1: slave read data.
REQ-015 m_axil_* same five channels, directions mirrored: master side toward downstream.
REQ-016 block_en  in  1  when high, watch-window hits are answered locally, not forwarded.
REQ-017 wr_count, rd_count  out  CNT_WIDTH  completed slave-side write / read transactions.
REQ-018 err_count  out  CNT_WIDTH  locally generated SLVERR responses.

Function
REQ-019 Write and read paths SHALL be independent FSMs, each with one outstanding transaction at most.
REQ-020 Write FSM states SHALL be IDLE, FWD, WAIT, RESP.
REQ-021 IDLE: awready and wready SHALL be high independently until each beat is captured; the other beat is awaited with the first held in a register.
REQ-022 Decision SHALL occur in the cycle both beats are held, with block_en sampled that cycle; hit = WATCH_MASK!=0 and (awaddr&WATCH_MASK)==(WATCH_BASE&WATCH_MASK).
REQ-023 hit and block_en SHALL go to RESP with bresp=2'b10, no master-side activity; otherwise go to FWD.
REQ-024 FWD: m_axil_awvalid and m_axil_wvalid SHALL rise the cycle after the decision, each dropping after its own handshake; after both handshakes, go to WAIT.
REQ-025 WAIT: m_axil_bready SHALL be high; on m_axil_bvalid, bresp is captured and the FSM goes to RESP.
REQ-026 RESP: s_axil_bvalid SHALL be held with stable bresp until s_axil_bready, then go to IDLE; wr_count increments at that handshake.
REQ-027 Read FSM SHALL mirror REQ-020..026 with states IDLE, FWD, WAIT, RESP; blocked reads return rdata 0, rresp 2'b10.
REQ-028 All slave and master payload outputs SHALL be registered; minimum forwarded latency is 1 cycle from slave handshake to master valid and 1 cycle from master response to slave valid.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 err_count SHALL increment once per local SLVERR response at the slave handshake; simultaneous write and read increments SHALL both be counted (+2).

Reset
REQ-031 rst SHALL force both FSMs to IDLE from any state, dropping any in-flight transaction.
REQ-032 Every valid output SHALL be 0 during and after reset, and awready/wready/arready SHALL be 1 after reset.
REQ-033 bresp, rresp, rdata and all m_axil payloads SHALL be 0 after reset; all counters SHALL be 0; stale flags SHALL be cleared.

Configuration
REQ-034 Macro AXIL_MITM_TAP_TIMEOUT_EN SHALL compile in the response timeout.
REQ-035 With the macro: a per-path counter runs in WAIT. Reaching TIMEOUT cycles SHALL go to RESP with SLVERR, which counts in err_count, and SHALL set a stale flag.
REQ-036 With the macro, while stale is set: m_bready/m_rready SHALL be high, the late response is discarded, and stale clears; IDLE does not accept new slave beats.
REQ-037 Without the macro: WAIT SHALL last indefinitely, no timeout or stale logic exists, and err_count counts blocks only.

Verification
REQ-038 Write 0x10/0xDEADBEEF, no block, downstream OKAY -> m_awaddr 0x10 forwarded, s_bresp 00, wr_count 1.
REQ-039 WATCH_BASE 0x1000, MASK 0xF000, block_en 1, read 0x1004 -> no m_arvalid, rdata 0, rresp 10, err_count 1.
REQ-040 W beat 3 cycles before AW beat -> single forward after AW arrives, wdata preserved, one bvalid.
REQ-041 TIMEOUT 8, macro on, downstream silent -> s_bresp 10 after 8 WAIT cycles; a later m_bvalid is absorbed; next write forwards normally.
REQ-042 rst asserted in write WAIT -> all valids 0 next cycle, counters 0, fresh write completes OKAY.
